// File: rtl/config_sink.sv
// config_sink
//   Turns 32-bit configuration words from the JTAG TAP into register-bank
//   writes in the clk domain. WRITE words are staged in a FIFO and released
//   only when a COMMIT word arrives. An ABORT word throws the staged writes
//   away.
//
//   Word layout: [31:30] opcode (00 NOP, 01 WRITE, 10 COMMIT, 11 ABORT),
//                [29:24] reserved, [23:16] addr, [15:0] data.
//
// Ports
//   clk            system clock; the only clock
//   reset          synchronous, active-low reset
//   config_strobe  TAP strobe, asynchronous to clk; a rising edge marks a new word
//   config_data    TAP word; stable from one strobe rise to the next
//   status_clr     one-cycle pulse that clears overflow and protocol_err
//   cfg_valid      write request to the register bank
//   cfg_ready      register bank accepts the write
//   cfg_addr       write address
//   cfg_data       write data
//   commit_done    one-cycle pulse when a commit has fully drained
//   busy           high while draining
//   level          number of staged entries
//   overflow       sticky; a WRITE was dropped because the FIFO was full
//   protocol_err   sticky; a word other than ABORT arrived while draining
module config_sink #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     config_strobe,
  input  logic [31:0]              config_data,
  input  logic                     status_clr,
  output logic                     cfg_valid,
  input  logic                     cfg_ready,
  output logic [7:0]               cfg_addr,
  output logic [15:0]              cfg_data,
  output logic                     commit_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     protocol_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_COMMIT = 2'b10;
  localparam logic [1:0] OP_ABORT  = 2'b11;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  // Strobe synchroniser plus one edge-detect flop.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   word_ev;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], config_strobe};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign word_ev = sync_q[SYNC_STAGES-1] & ~edge_q;

  // config_data is already stable by the time word_ev fires, so it is
  // decoded straight from the port without a capture register.
  logic [1:0]  op;
  logic        unused_reserved;
  assign op              = config_data[31:30];
  assign unused_reserved = ^config_data[29:24];

  // Staging FIFO. Pointers carry one extra bit so full and empty differ.
  logic [23:0]   mem_q [DEPTH];
  logic [LW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_inc, level_w;
  logic [23:0]   head, head_next;
  logic          fifo_full, fifo_empty;

  state_t      state_q;
  logic        cfg_valid_q, commit_done_q, overflow_q, protocol_err_q;
  logic        overflow_d, protocol_err_d;
  logic [7:0]  cfg_addr_q;
  logic [15:0] cfg_data_q;
  logic        push, handshake;

  assign level_w    = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (level_w == LW'(DEPTH));
  assign fifo_empty = (level_w == '0);
  assign rd_ptr_inc = rd_ptr_q + LW'(1);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign head_next  = mem_q[rd_ptr_inc[AW-1:0]];

  assign push      = word_ev && (state_q == IDLE) && (op == OP_WRITE) && !fifo_full;
  assign handshake = cfg_valid_q & cfg_ready;

  // Sticky flags: a set in the same cycle as status_clr wins.
  always_comb begin
    overflow_d     = overflow_q;
    protocol_err_d = protocol_err_q;
    if (status_clr) begin
      overflow_d     = 1'b0;
      protocol_err_d = 1'b0;
    end
    if (word_ev && (state_q == IDLE) && (op == OP_WRITE) && fifo_full)
      overflow_d = 1'b1;
    if (word_ev && (state_q == DRAIN) && (op != OP_ABORT))
      protocol_err_d = 1'b1;
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q[AW-1:0]] <= config_data[23:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cfg_valid_q    <= 1'b0;
      cfg_addr_q     <= '0;
      cfg_data_q     <= '0;
      commit_done_q  <= 1'b0;
      overflow_q     <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      commit_done_q  <= 1'b0;
      overflow_q     <= overflow_d;
      protocol_err_q <= protocol_err_d;
      case (state_q)
        IDLE: begin
          if (word_ev) begin
            case (op)
              OP_WRITE: begin
                if (!fifo_full)
                  wr_ptr_q <= wr_ptr_q + LW'(1);
              end
              OP_COMMIT: begin
                if (fifo_empty) begin
                  commit_done_q <= 1'b1;
                end else begin
                  state_q                  <= DRAIN;
                  cfg_valid_q              <= 1'b1;
                  {cfg_addr_q, cfg_data_q} <= head;
                end
              end
              OP_ABORT: begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
              end
              default: ;
            endcase
          end
        end
        DRAIN: begin
          // ABORT has priority; a handshake in the same cycle has already
          // reached the register bank, so nothing needs undoing.
          if (word_ev && (op == OP_ABORT)) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cfg_valid_q <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            state_q     <= IDLE;
          end else if (handshake) begin
            rd_ptr_q <= rd_ptr_inc;
            if (level_w == LW'(1)) begin
              cfg_valid_q   <= 1'b0;
              cfg_addr_q    <= '0;
              cfg_data_q    <= '0;
              commit_done_q <= 1'b1;
              state_q       <= IDLE;
            end else begin
              // Present the next entry immediately for back-to-back transfers.
              {cfg_addr_q, cfg_data_q} <= head_next;
            end
          end
        end
      endcase
    end
  end

  assign cfg_valid    = cfg_valid_q;
  assign cfg_addr     = cfg_addr_q;
  assign cfg_data     = cfg_data_q;
  assign commit_done  = commit_done_q;
  assign busy         = (state_q == DRAIN);
  assign level        = level_w;
  assign overflow     = overflow_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_config_sink.sv
module tb_config_sink;

  localparam int DEPTH = 8;
  localparam int S     = 2;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] CM  = 2'b10;
  localparam logic [1:0] AB  = 2'b11;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  config_strobe;
  logic [31:0]           config_data;
  logic                  status_clr;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [7:0]            cfg_addr;
  logic [15:0]           cfg_data;
  logic                  commit_done;
  logic                  busy;
  logic [$clog2(DEPTH):0] level;
  logic                  overflow;
  logic                  protocol_err;

  always #5 clk = ~clk;

  config_sink #(.DEPTH(DEPTH), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .reset        (reset),
    .config_strobe(config_strobe),
    .config_data  (config_data),
    .status_clr   (status_clr),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .commit_done  (commit_done),
    .busy         (busy),
    .level        (level),
    .overflow     (overflow),
    .protocol_err (protocol_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: staged writes, writes still owed to the register bank,
  // outstanding commit_done pulses and the two sticky flags.
  logic [23:0] staged[$];
  logic [23:0] exp_xfer[$];
  int          exp_done = 0;
  bit          m_ovf    = 1'b0;
  bit          m_perr   = 1'b0;

  // 0: ready low, 1: ready high, 2: random ready
  int ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    cfg_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       cfg_ready = 1'b0;
        1:       cfg_ready = 1'b1;
        default: cfg_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every DUT-presented transfer or commit_done.
  logic [23:0] mon_exp;
  logic [23:0] prev_word;
  bit          prev_stall = 1'b0;
  bit          prev_done  = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (prev_stall && cfg_valid)
          chk("hold_stable", {cfg_addr, cfg_data}, prev_word);
        if (cfg_valid && cfg_ready) begin
          if (exp_xfer.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_unexpected: got addr=%h data=%h, expected no transfer", cfg_addr, cfg_data);
          end else begin
            mon_exp = exp_xfer.pop_front();
            chk("xfer", {cfg_addr, cfg_data}, mon_exp);
            $display("xfer addr=%h data=%h", cfg_addr, cfg_data);
          end
        end
        if (commit_done) begin
          // expect: not a repeat pulse, valid low, not busy, pulse owed, queue drained
          chk("commit_done_ok",
              {prev_done, cfg_valid, busy, exp_done > 0, exp_xfer.size() == 0}, 5'b00011);
          if (exp_done > 0) exp_done--;
          $display("commit_done");
        end
        prev_stall = cfg_valid && !cfg_ready;
        prev_word  = {cfg_addr, cfg_data};
        prev_done  = commit_done;
      end else begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_valid", cfg_valid, 0);
    chk("rst_addr", cfg_addr, 0);
    chk("rst_data", cfg_data, 0);
    chk("rst_done", commit_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_perr", protocol_err, 0);
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    reset = 1'b0;
    staged.delete();
    exp_xfer.delete();
    exp_done = 0;
    m_ovf    = 1'b0;
    m_perr   = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_level"}, level, staged.size());
    chk({tag, "_ovf"}, overflow, m_ovf);
    chk({tag, "_perr"}, protocol_err, m_perr);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    status_clr = 1'b1;
    @(posedge clk);
    #1;
    status_clr = 1'b0;
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    chk("clr_ovf", overflow, 0);
    chk("clr_perr", protocol_err, 0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (exp_xfer.size() == 0 && exp_done == 0 && !busy && !commit_done) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_finished", ok, 1);
  endtask

  // Issues one word. The strobe rise is first sampled at edge N; the word
  // must have no visible effect after N+S-1 and its full effect after N+S.
  task automatic send_word(input logic [1:0] op, input logic [7:0] addr, input logic [15:0] data);
    bit in_drain;
    int lvl_before;
    @(posedge clk);
    #1;
    config_data   = {op, 6'($urandom), addr, data};
    config_strobe = 1'b1;
    in_drain      = (exp_xfer.size() != 0);
    lvl_before    = in_drain ? exp_xfer.size() : staged.size();
    repeat (S) @(posedge clk);
    #1;
    chk("pre_level", level, lvl_before);
    if (op == CM && !in_drain)
      chk("pre_commit", {commit_done, cfg_valid, busy}, 3'b000);
    @(posedge clk);
    #1;
    if (in_drain) begin
      if (op == AB) begin
        exp_xfer.delete();
        exp_done--;
        chk("abort_drain", {cfg_valid, busy, level}, 0);
      end else begin
        m_perr = 1'b1;
        chk("perr_set", protocol_err, 1);
        chk("perr_level", level, exp_xfer.size());
      end
    end else begin
      case (op)
        NOP: chk("nop_level", level, staged.size());
        WR: begin
          if (staged.size() < DEPTH) staged.push_back({addr, data});
          else m_ovf = 1'b1;
          chk("write_level", level, staged.size());
          chk("write_ovf", overflow, m_ovf);
        end
        CM: begin
          exp_done++;
          if (staged.size() == 0) begin
            chk("commit_empty", {commit_done, cfg_valid, busy}, 3'b100);
          end else begin
            exp_xfer = staged;
            staged.delete();
            chk("commit_start", {cfg_valid, busy, commit_done}, 3'b110);
            chk("commit_head", {cfg_addr, cfg_data}, exp_xfer[0]);
          end
        end
        default: begin
          staged.delete();
          chk("abort_level", level, 0);
        end
      endcase
    end
    $display("word op=%0d addr=%h data=%h level=%0d ovf=%0d perr=%0d",
             op, addr, data, level, overflow, protocol_err);
    config_strobe = 1'b0;
    repeat (S + 2) @(posedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] op;
    int         n;
    int         r;

    reset         = 1'b0;
    config_strobe = 1'b0;
    config_data   = '0;
    status_clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    reset = 1'b1;

    // Three writes, commit, ready high: back-to-back transfers in order.
    ready_mode = 1;
    send_word(WR, 8'h10, 16'hAAAA);
    send_word(WR, 8'h11, 16'h5555);
    send_word(WR, 8'h12, 16'h1234);
    send_word(CM, 8'h00, 16'h0000);
    wait_idle();
    check_state("basic");

    // Nine writes into eight entries: ninth dropped, overflow sticky.
    for (int i = 0; i < 9; i++)
      send_word(WR, 8'($urandom), 16'($urandom));
    chk("full_level", level, DEPTH);
    chk("full_ovf", overflow, 1);
    send_word(CM, 8'h00, 16'h0000);
    wait_idle();
    check_state("ovf");
    pulse_clr();

    // Stall with ready low, then ABORT mid-drain.
    ready_mode = 0;
    send_word(WR, 8'h21, 16'hBEEF);
    send_word(WR, 8'h22, 16'hCAFE);
    send_word(CM, 8'h00, 16'h0000);
    repeat (5) @(posedge clk);
    send_word(AB, 8'h00, 16'h0000);
    wait_idle();
    check_state("abort");

    // WRITE during drain is rejected; drain then completes normally.
    send_word(WR, 8'h31, 16'h0101);
    send_word(WR, 8'h32, 16'h0202);
    send_word(CM, 8'h00, 16'h0000);
    send_word(WR, 8'h33, 16'h0303);
    ready_mode = 1;
    wait_idle();
    check_state("perr");
    pulse_clr();

    // COMMIT with nothing staged.
    send_word(CM, 8'h00, 16'h0000);
    wait_idle();

    // Reset after one of four transfers.
    ready_mode = 0;
    for (int i = 0; i < 4; i++)
      send_word(WR, 8'(8'h40 + i), 16'($urandom));
    send_word(CM, 8'h00, 16'h0000);
    @(posedge clk);
    #1;
    ready_mode = 1;
    @(posedge clk);
    #1;
    ready_mode = 0;
    chk("one_xfer_level", level, 3);
    do_reset(2);
    send_word(CM, 8'h00, 16'h0000);
    wait_idle();
    check_state("post_reset");

    // Randomised traffic with random backpressure.
    for (int it = 0; it < 20; it++) begin
      ready_mode = 2;
      n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++) begin
        r  = $urandom_range(0, 15);
        op = (r == 0) ? AB : (r == 1) ? NOP : WR;
        send_word(op, 8'($urandom), 16'($urandom));
      end
      send_word(CM, 8'h00, 16'h0000);
      wait_idle();
      check_state("rand");
      if ($urandom_range(0, 3) == 0) pulse_clr();
    end

    chk("final_xfer_queue", exp_xfer.size(), 0);
    chk("final_done_owed", exp_done, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
